// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with far-end pause control.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit (11-bit frames).
module uart_tx_fifo #(
    parameter int CLK_RATE   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        CLK_I,
    input  logic                        RST_I,
    input  logic                        WE_I,
    input  logic [7:0]                  DSEND_I,
    output logic                        TX_READY_O,
    input  logic                        SEND_PAUSE_I,
    output logic                        TX_O,
    output logic                        TX_BUSY_O,
    output logic                        TX_DONE_O,
    output logic                        TX_EMPTY_O,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL_O
);
    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic          push_s, pop_s, start_ok_s, baud_last_s;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // FIFO bookkeeping: pointers, occupancy and the registered full/empty flags
    always_comb begin
        push_s = WE_I && !full_q;
        if (push_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == COUNT_FULL);
        empty_d = (count_d == {(AW+1){1'b0}});
    end

    // Frame sequencer; line outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        pop_s       = 1'b0;
        start_ok_s  = !empty_q && !SEND_PAUSE_I;
        baud_last_s = (baud_q == BAUD_LAST);
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = ST_START;
                    baud_d  = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    state_d   = ST_DATA;
                    baud_d    = {CW{1'b0}};
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d  = {CW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last_s) begin
                    state_d = ST_STOP;
                    baud_d  = {CW{1'b0}};
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = {CW{1'b0}};
                    if (start_ok_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {CW{1'b0}};
            end
        endcase

`ifdef UART_TX_PARITY_EN
        if (pop_s) begin
            parity_d = even_parity(mem_q[rptr_q]);
        end else begin
            parity_d = parity_q;
        end
`endif

        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
    end

    // Byte storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLK_I) begin
        if (push_s) begin
            mem_q[wptr_q] <= DSEND_I;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wptr_q    <= {AW{1'b0}};
            rptr_q    <= {AW{1'b0}};
            count_q   <= {(AW+1){1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            state_q   <= ST_IDLE;
            baud_q    <= {CW{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign TX_O       = tx_q;
    assign TX_BUSY_O  = busy_q;
    assign TX_DONE_O  = done_q;
    assign TX_READY_O = !full_q;
    assign TX_EMPTY_O = empty_q;
    assign LEVEL_O    = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus with cycle checks plus a serial-line scoreboard monitor.
module tb_uart_tx_fifo;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst, we, pause;
    logic [7:0] din;
    logic       tx_ready, tx, busy, done, empty;
    logic [4:0] level;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int n, r, w, c, d0, stop_s;
    logic [7:0] exp_q[$];
    logic       bits_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    uart_tx_fifo #(
        .CLK_RATE(1_000_000),
        .BAUD_RATE(100_000),
        .FIFO_DEPTH(16)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .WE_I(we),
        .DSEND_I(din),
        .TX_READY_O(tx_ready),
        .SEND_PAUSE_I(pause),
        .TX_O(tx),
        .TX_BUSY_O(busy),
        .TX_DONE_O(done),
        .TX_EMPTY_O(empty),
        .LEVEL_O(level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk_int(input string name, input int actual, input int expected);
        vectors = vectors + 1;
        if (actual != expected) begin
            miscompares = miscompares + 1;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic chk_bit(input string name, input logic actual, input logic expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    // Serial-line monitor: decodes each frame and compares it with the scoreboard head
    int         mon_cnt = 0;
    logic       mon_active = 1'b0;
    logic [7:0] mon_byte, mon_exp;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = 8'h00;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt == CPB / 2) chk_bit("mon_start", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                if (mon_cnt == CPB / 2 + CPB * (i + 1)) mon_byte[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            if (mon_cnt == CPB / 2 + CPB * 9 && exp_q.size() > 0) chk_bit("mon_parity", tx, ^exp_q[0]);
`endif
            if (mon_cnt == CPB / 2 + CPB * (NBITS - 1)) begin
                chk_bit("mon_stop", tx, 1'b1);
                if (exp_q.size() == 0) begin
                    vectors     = vectors + 1;
                    miscompares = miscompares + 1;
                    $display("FAIL mon_byte @cyc %0d: got %02h, expected no frame", cyc, mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk_int("mon_byte", int'(mon_byte), int'(mon_exp));
                end
            end
            if (mon_cnt == F - 1) mon_active = 1'b0;
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; din = 8'h00; pause = 1'b0;
        tick(); tick(); tick();
        chk_bit("rst_tx", tx, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_empty", empty, 1'b1);
        chk_bit("rst_ready", tx_ready, 1'b1);
        chk_int("rst_level", int'(level), 0);
        rst = 1'b0;
        tick();

        // 1: single byte 0xA5, exact frame timing
        n = cyc; we = 1'b1; din = 8'hA5; exp_q.push_back(8'hA5);
        tick(); we = 1'b0;
        chk_int("t1_level_n1", int'(level), 1);
        chk_bit("t1_tx_n1", tx, 1'b1);
        goto(n + 2);
        chk_bit("t1_start_first", tx, 1'b0);
        chk_bit("t1_busy", busy, 1'b1);
        chk_int("t1_level_n2", int'(level), 0);
        goto(n + 11);
        chk_bit("t1_start_last", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            goto(n + 12 + CPB * i + 5);
            chk_bit("t1_data_bit", tx, bits_a5[i]);
        end
`ifdef UART_TX_PARITY_EN
        goto(n + 97);
        chk_bit("t1_parity", tx, 1'b0);
        stop_s = n + 102;
`else
        stop_s = n + 92;
`endif
        goto(stop_s + 3);
        chk_bit("t1_stop", tx, 1'b1);
        goto(stop_s + 8);
        chk_bit("t1_done_early", done, 1'b0);
        goto(stop_s + 9);
        chk_bit("t1_done", done, 1'b1);
        chk_bit("t1_busy_stop", busy, 1'b1);
        goto(stop_s + 10);
        chk_bit("t1_done_after", done, 1'b0);
        chk_bit("t1_idle_busy", busy, 1'b0);
        chk_bit("t1_idle_tx", tx, 1'b1);

        // 2: paused fill of 17 bytes, the last one dropped
        pause = 1'b1;
        for (int i = 0; i < 17; i++) begin
            we = 1'b1; din = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
            if (i == 16) chk_bit("t2_ready_at_17th", tx_ready, 1'b0);
            tick();
        end
        we = 1'b0;
        goto(cyc + 5);
        chk_int("t2_level", int'(level), 16);
        chk_bit("t2_ready", tx_ready, 1'b0);
        chk_bit("t2_tx", tx, 1'b1);
        chk_bit("t2_busy", busy, 1'b0);
        chk_bit("t2_empty", empty, 1'b0);

        // 3: release pause, 16 back-to-back frames
        r = cyc; d0 = done_cnt; pause = 1'b0;
        goto(r + 1);
        chk_bit("t3_first_start", tx, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            goto(r + F * k);
            chk_bit("t3_done", done, 1'b1);
            chk_int("t3_level", int'(level), 16 - k);
            goto(r + F * k + 1);
            chk_bit("t3_no_gap", tx, 1'b0);
        end
        chk_bit("t3_empty", empty, 1'b1);
        goto(r + 16 * F + 1);
        chk_bit("t3_end_busy", busy, 1'b0);
        chk_bit("t3_end_tx", tx, 1'b1);
        chk_int("t3_done_count", done_cnt - d0, 16);

        // 4: pause asserted mid-frame holds the second byte
        w = cyc; we = 1'b1; din = 8'h5A; exp_q.push_back(8'h5A);
        tick(); din = 8'hC3; exp_q.push_back(8'hC3);
        tick(); we = 1'b0;
        chk_int("t4_level", int'(level), 1);
        chk_bit("t4_start", tx, 1'b0);
        goto(w + 30); pause = 1'b1;
        goto(w + F + 1);
        chk_bit("t4_done1", done, 1'b1);
        goto(w + F + 2);
        chk_bit("t4_hold_tx", tx, 1'b1);
        chk_bit("t4_hold_busy", busy, 1'b0);
        chk_int("t4_hold_level", int'(level), 1);
        goto(w + F + 20);
        chk_bit("t4_hold_tx_late", tx, 1'b1);
        chk_int("t4_hold_level_late", int'(level), 1);
        r = cyc; pause = 1'b0;
        tick();
        chk_bit("t4_restart_tx", tx, 1'b0);
        chk_bit("t4_restart_busy", busy, 1'b1);
        chk_int("t4_restart_level", int'(level), 0);
        goto(r + F + 1);
        chk_bit("t4_end_busy", busy, 1'b0);

        // 5: reset during data bit 3 aborts and flushes
        w = cyc; we = 1'b1; din = 8'h96; exp_q.push_back(8'h96);
        tick(); din = 8'h11; exp_q.push_back(8'h11);
        tick(); we = 1'b0;
        goto(w + 45);
        chk_bit("t5_bit3", tx, 1'b0);
        chk_int("t5_level_pre", int'(level), 1);
        rst = 1'b1; exp_q.delete(); d0 = done_cnt;
        tick(); rst = 1'b0;
        chk_bit("t5_tx", tx, 1'b1);
        chk_bit("t5_busy", busy, 1'b0);
        chk_int("t5_level", int'(level), 0);
        chk_bit("t5_empty", empty, 1'b1);
        chk_bit("t5_done", done, 1'b0);
        goto(w + 46 + F + 5);
        chk_bit("t5_quiet_tx", tx, 1'b1);
        chk_int("t5_no_done", done_cnt - d0, 0);

        // 6: write while full in the pop cycle is dropped, next write accepted
        pause = 1'b1;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; din = 8'h20 + 8'(i); exp_q.push_back(8'h20 + 8'(i));
            tick();
        end
        we = 1'b0;
        tick();
        chk_int("t6_full_level", int'(level), 16);
        chk_bit("t6_full_ready", tx_ready, 1'b0);
        c = cyc; pause = 1'b0; we = 1'b1; din = 8'h3C;
        tick(); din = 8'h3D; exp_q.push_back(8'h3D);
        chk_int("t6_level_c1", int'(level), 15);
        chk_bit("t6_ready_c1", tx_ready, 1'b1);
        tick(); we = 1'b0;
        chk_int("t6_level_c2", int'(level), 16);
        chk_bit("t6_ready_c2", tx_ready, 1'b0);
        goto(c + 17 * F + 5);
        chk_bit("t6_drained_empty", empty, 1'b1);
        chk_bit("t6_drained_busy", busy, 1'b0);
        chk_int("t6_scoreboard_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
